// File: rtl/aes_pkg.sv
// AES helpers: S-box, GF(2^8) arithmetic, round constants, byte/word access.
// Latency: n/a (pure functions and types).
// Backpressure: n/a.
// Byte order: byte 0 of a block or word sits in the most significant bits.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b lives at bit offset (255-b)*8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round constant, 1-based index.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] blk, input logic [3:0] i);
    return blk[{~i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] blk, input logic [1:0] i);
    return blk[{~i, 5'b00000} +: 32];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One AES round: SubBytes -> ShiftRows -> MixColumns (skipped on last) -> AddRoundKey.
// Latency: combinational.
// Backpressure: none; caller decides when to register the result.
// Ports: state_i current state, rk_i round key, last_i final round, state_o next state.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] sb, sr, mc;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[8*(15-i) +: 8] = sub_byte(get_byte(state_i, 4'(i)));
    end
    // Byte 4c+r is row r of column c; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(15-(4*c+r)) +: 8] = sb[8*(15-(4*((c+r)%4)+r)) +: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[32*(3-c) +: 32] = mix_column(sr[32*(3-c) +: 32]);
    end
    state_o = (last_i ? sr : mc) ^ rk_i;
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryptor, one round per clock with on-the-fly key expansion.
// Latency: out_valid rises NR edges after the accepting edge; one block per NR+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low whenever not IDLE.
// Ports: clk, rst (async active-low), key/plaintext/in_valid/in_ready on the input side,
//        ciphertext/out_valid/out_ready on the output side, busy high in ROUND and DONE.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key,
  input  logic [127:0]        plaintext,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [127:0]        ciphertext,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int NR = KEY_BITS / 32 + 6;
  localparam logic [3:0] NR_W = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_enc_iter: KEY_BITS must be 128 or 256");
  end

  state_t              state_q, state_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [127:0]        blk_q, blk_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [127:0]        ct_q, ct_d;

  logic [127:0]        rk;       // round key for round rnd_q
  logic [KEY_BITS-1:0] key_nxt;  // key register contents after this round
  logic [127:0]        round_out;

  if (KEY_BITS == 128) begin : g_ks128
    // key_q holds the previous round key; derive the next one in place.
    logic [31:0] t, n0, n1, n2, n3;
    always_comb begin
      t  = sub_word(rot_word(get_word(key_q, 2'd3))) ^ {rcon(rnd_q), 24'h0};
      n0 = get_word(key_q, 2'd0) ^ t;
      n1 = get_word(key_q, 2'd1) ^ n0;
      n2 = get_word(key_q, 2'd2) ^ n1;
      n3 = get_word(key_q, 2'd3) ^ n2;
      rk      = {n0, n1, n2, n3};
      key_nxt = {n0, n1, n2, n3};
    end
  end else begin : g_ks256
    // key_q is an 8-word window. Odd rounds use its low half unchanged;
    // even rounds slide the window forward and use the new high half.
    logic [127:0] hi, lo;
    logic [31:0]  h0, h1, h2, h3, l0, l1, l2, l3;
    always_comb begin
      hi = key_q[255:128];
      lo = key_q[127:0];
      h0 = get_word(hi, 2'd0) ^ sub_word(rot_word(get_word(lo, 2'd3)))
           ^ {rcon({1'b0, rnd_q[3:1]}), 24'h0};
      h1 = get_word(hi, 2'd1) ^ h0;
      h2 = get_word(hi, 2'd2) ^ h1;
      h3 = get_word(hi, 2'd3) ^ h2;
      l0 = get_word(lo, 2'd0) ^ sub_word(h3);
      l1 = get_word(lo, 2'd1) ^ l0;
      l2 = get_word(lo, 2'd2) ^ l1;
      l3 = get_word(lo, 2'd3) ^ l2;
      if (rnd_q[0]) begin
        rk      = lo;
        key_nxt = key_q;
      end else begin
        rk      = {h0, h1, h2, h3};
        key_nxt = {h0, h1, h2, h3, l0, l1, l2, l3};
      end
    end
  end

  aes_round u_round (
    .state_i (blk_q),
    .rk_i    (rk),
    .last_i  (rnd_q == NR_W),
    .state_o (round_out)
  );

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    key_d     = key_q;
    ct_d      = ct_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          blk_d   = plaintext ^ key[KEY_BITS-1 -: 128];
          key_d   = key;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = round_out;
        key_d = key_nxt;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == NR_W) begin
          ct_d    = round_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  assign ciphertext = ct_q;

endmodule
